// File: rtl/ahb_ext_responder.sv
// ahb_ext_responder: AHB-Lite external slave backed by word storage,
// with programmable OKAY wait states and a two-cycle ERROR response.
module ahb_ext_responder #(
  parameter int AHBW        = 64,
  parameter int PA_BITS     = 34,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                HSEL,
  input  logic [PA_BITS-1:0]  HADDR,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [AHBW-1:0]     HWDATA,
  input  logic [AHBW/8-1:0]   HWSTRB,
  input  logic                HREADY,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic [AHBW-1:0]     HRDATA
);
  localparam int NB  = AHBW / 8;
  localparam int BO  = $clog2(NB);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TOP = BO + IW;
  localparam logic [IW:0] DEPTH_L = (IW + 1)'(DEPTH);
  localparam logic [3:0]  WS_M1 =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  state_t          state, nstate;
  logic [3:0]      cnt, ncnt;
  logic [IW-1:0]   idx;
  logic            wr, err, pend;
  logic [AHBW-1:0] mem [DEPTH];

  logic            open_ph, accept, a_err, wr_en;
  logic [IW-1:0]   a_idx;
  logic            unused_ok;

  assign unused_ok = HTRANS[0];

  // Only IDLE and ERR2 present HREADYOUT=1, so only they can take an address.
  assign open_ph = (state == IDLE) || (state == ERR2);
  assign accept  = open_ph && HSEL && HREADY && HTRANS[1];
  assign a_idx   = HADDR[BO +: IW];
  assign a_err   = ((HADDR >> TOP) != '0) ||
                   ({1'b0, a_idx} >= DEPTH_L) ||
                   (HSIZE > 3'(BO));

  // Completing cycle of an OKAY transfer is always an IDLE-state cycle.
  assign wr_en = pend && wr && !err && (state == IDLE) && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nstate;
      cnt   <= ncnt;
    end
  end

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    unique case (state)
      IDLE, ERR2: begin
        nstate = IDLE;
        if (accept) begin
          if (a_err) begin
            nstate = ERR1;
          end else if (WAIT_STATES > 0) begin
            nstate = WAIT;
            ncnt   = WS_M1;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) nstate = IDLE;
        else ncnt = cnt - 4'd1;
      end
      ERR1: nstate = ERR2;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = open_ph;
    HRESP     = (state == ERR1) || (state == ERR2);
    HRDATA    = '0;
    if (pend && !wr && !err && (state == IDLE || state == WAIT))
      HRDATA = mem[idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx  <= '0;
      wr   <= 1'b0;
      err  <= 1'b0;
      pend <= 1'b0;
    end else if (accept) begin
      idx  <= a_idx;
      wr   <= HWRITE;
      err  <= a_err;
      pend <= 1'b1;
    end else if (open_ph) begin
      pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++)
        if (HWSTRB[i]) mem[idx][8*i +: 8] <= HWDATA[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_ext_responder.sv
// tb_ahb_ext_responder: scoreboard bench driving two responders
// (2 wait states and 0 wait states) through one pipelined AHB master.
module tb_ahb_ext_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        which;
  logic        hsel, hwrite;
  logic [33:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [63:0] hwdata;
  logic [7:0]  hwstrb;
  logic        ro_a, ro_b, rs_a, rs_b;
  logic [63:0] rd_a, rd_b;
  logic        ro, rs;
  logic [63:0] rd;

  assign ro = which ? ro_b : ro_a;
  assign rs = which ? rs_b : rs_a;
  assign rd = which ? rd_b : rd_a;

  ahb_ext_responder #(.WAIT_STATES(2)) dut_a (
    .clk(clk), .reset(rst), .HSEL(hsel & ~which), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HWSTRB(hwstrb), .HREADY(ro), .HREADYOUT(ro_a), .HRESP(rs_a),
    .HRDATA(rd_a));

  ahb_ext_responder #(.WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(rst), .HSEL(hsel & which), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HWSTRB(hwstrb), .HREADY(ro), .HREADYOUT(ro_b), .HRESP(rs_b),
    .HRDATA(rd_b));

  typedef struct {
    bit          err;
    bit          rd;
    int          waits;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] ref_mem [2][256];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] last_rd;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Reference: word address beyond storage or size wider than 8 bytes errors.
  function automatic bit is_bad(input logic [33:0] a, input logic [2:0] sz);
    return ((a >> 3) >= 34'd256) || (sz > 3'd3);
  endfunction

  task automatic issue(input bit w, input logic [33:0] a,
                       input logic [2:0] sz, input logic [63:0] d,
                       input logic [7:0] s);
    bit   rdy;
    int   b;
    int   wi;
    exp_t e;
    hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = w; hsize = sz;
    b = 0;
    do begin
      @(negedge clk); rdy = ro;
      @(posedge clk); #1; b++;
    end while (!rdy && b < 40);
    check("issue_accept", 64'(rdy), 64'd1);
    hsel = 1'b0; htrans = 2'b00;
    hwdata = d; hwstrb = s;
    e.err   = is_bad(a, sz);
    e.rd    = !w;
    e.waits = e.err ? 1 : (which ? 0 : 2);
    e.data  = '0;
    if (!e.err) begin
      wi = int'(a >> 3);
      if (w) begin
        for (int i = 0; i < 8; i++)
          if (s[i]) ref_mem[int'(which)][wi][8*i +: 8] = d[8*i +: 8];
      end else begin
        e.data = ref_mem[int'(which)][wi];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 60) begin
      @(posedge clk); #1; b++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rand_run(input int n);
    for (int k = 0; k < n; k++) begin
      int          r;
      logic [33:0] a;
      logic [2:0]  sz;
      r  = int'($urandom_range(9));
      a  = 34'($urandom_range(15)) * 34'd8 + 34'($urandom_range(7));
      sz = 3'($urandom_range(3));
      if (r == 0) a = a | (34'd1 << $urandom_range(33, 11));
      else if (r == 1) sz = 3'($urandom_range(7, 4));
      issue(bit'($urandom_range(1)), a, sz, {$urandom, $urandom},
            8'($urandom));
      if ($urandom_range(3) == 0) drain();
    end
    drain();
  endtask

  task automatic init_words();
    for (int i = 0; i < 16; i++)
      issue(1'b1, 34'(i * 8), 3'd3, {$urandom, $urandom}, 8'hFF);
    drain();
  endtask

  // Monitor: tracks each accepted data phase and scores it on completion.
  bit   in_dp = 0;
  bit   resp_ok;
  int   nw;
  exp_t m;
  always @(negedge clk) begin
    if (rst) begin
      in_dp = 0;
    end else begin
      if (in_dp) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_phase: got data phase, expected none");
          in_dp = 0;
        end else if (!ro) begin
          nw++;
          if (rs !== exp_q[0].err) resp_ok = 0;
          if (nw > 30) begin
            n_chk++; n_fail++;
            $display("FAIL ready_timeout: got %0d waits, expected %0d",
                     nw, exp_q[0].waits);
            void'(exp_q.pop_front());
            in_dp = 0;
          end
        end else begin
          m = exp_q.pop_front();
          check("wait_count", 64'(nw), 64'(m.waits));
          check("hresp", 64'(rs), 64'(m.err));
          check("hresp_in_wait", 64'(resp_ok), 64'd1);
          check(m.rd ? "hrdata" : "hrdata_zero", rd,
                (m.rd && !m.err) ? m.data : 64'd0);
          if (m.rd) last_rd = rd;
          in_dp = 0;
        end
      end
      if (ro && hsel && htrans[1]) begin
        in_dp = 1; nw = 0; resp_ok = 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    which = 1'b0; hsel = 1'b0; htrans = 2'b00; haddr = '0;
    hwrite = 1'b0; hsize = 3'd3; hwdata = '0; hwstrb = '0;
    #1;
    check("rst_ready_a", 64'(ro_a), 64'd1);
    check("rst_resp_a", 64'(rs_a), 64'd0);
    check("rst_rdata_a", rd_a, 64'd0);
    check("rst_ready_b", 64'(ro_b), 64'd1);
    check("rst_rdata_b", rd_b, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    init_words();
    issue(1'b1, 34'h10, 3'd3, 64'h1122334455667788, 8'hFF);
    issue(1'b0, 34'h10, 3'd3, 64'd0, 8'h00);
    drain();
    check("write_read_full", last_rd, 64'h1122334455667788);

    issue(1'b1, 34'h10, 3'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    issue(1'b0, 34'h10, 3'd3, 64'd0, 8'h00);
    drain();
    check("partial_write", last_rd, 64'h11223344AAAAAAAA);

    issue(1'b0, 34'h800, 3'd3, 64'd0, 8'h00);
    issue(1'b1, 34'h800, 3'd3, 64'hDEADBEEFCAFEF00D, 8'hFF);
    issue(1'b0, 34'h10, 3'b100, 64'd0, 8'h00);
    issue(1'b0, 34'h0, 3'd3, 64'd0, 8'h00);
    issue(1'b0, 34'h10, 3'd3, 64'd0, 8'h00);
    drain();

    issue(1'b1, 34'h8, 3'd3, 64'd0, 8'hFF);
    drain();
    issue(1'b1, 34'h8, 3'd3, 64'hFF, 8'hFF);
    @(negedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_ready", 64'(ro_a), 64'd1);
    check("async_rst_resp", 64'(rs_a), 64'd0);
    check("async_rst_rdata", rd_a, 64'd0);
    @(posedge clk); @(negedge clk); @(posedge clk);
    #1 rst = 1'b0;
    ref_mem[0][1] = 64'd0;
    issue(1'b0, 34'h8, 3'd3, 64'd0, 8'h00);
    drain();
    check("aborted_write", last_rd, 64'd0);

    hsel = 1'b1; htrans = 2'b00; haddr = 34'h10; hwrite = 1'b1;
    hwdata = 64'h5555555555555555; hwstrb = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      check("idle_trans_ready", 64'(ro), 64'd1);
      check("idle_trans_resp", 64'(rs), 64'd0);
    end
    hsel = 1'b0; htrans = 2'b10;
    repeat (3) begin
      @(negedge clk);
      check("unsel_ready", 64'(ro), 64'd1);
      check("unsel_resp", 64'(rs), 64'd0);
    end
    htrans = 2'b00;
    @(posedge clk); #1;
    issue(1'b0, 34'h10, 3'd3, 64'd0, 8'h00);
    drain();

    rand_run(80);

    which = 1'b1;
    @(posedge clk); #1;
    init_words();
    issue(1'b1, 34'h0, 3'd3, 64'd5, 8'hFF);
    issue(1'b0, 34'h0, 3'd3, 64'd0, 8'h00);
    drain();
    check("zero_wait_b2b", last_rd, 64'd5);
    rand_run(60);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_ext_responder.md
AHB_EXT_RESPONDER -- requirements
Module: ahb_ext_responder

Interface
REQ-001 Parameter AHBW, default 64: AHB data width in bits; legal values are 32 and 64.
REQ-002 Parameter PA_BITS, default 34: width of the physical address.
REQ-003 Parameter DEPTH, default 256: number of AHBW-wide storage words.
REQ-004 Parameter WAIT_STATES, default 2: number of wait cycles inserted per OKAY data phase; legal range is 0..15.
REQ-005 Port list (name, direction, width, meaning):
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- HSEL  in  1  block select, driven from the SoC's HSELEXT.
- HADDR  in  PA_BITS  address-phase address.
- HTRANS  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, log2 of bytes.
- HWDATA  in  AHBW  data-phase write data.
- HWSTRB  in  AHBW/8  data-phase byte strobes.
- HREADY  in  1  bus-level ready (the fabric mux output).
- HREADYOUT  out  1  this block's ready; drives the SoC's HREADYEXT.
- HRESP  out  1  1 = ERROR; drives the SoC's HRESPEXT.
- HRDATA  out  AHBW  read data; drives the SoC's HRDATAEXT.

Function
REQ-006 An address phase SHALL be accepted only on a rising clk edge where HSEL=1, HREADY=1 and HTRANS[1]=1. On acceptance the block SHALL register the word index HADDR[log2(AHBW/8)+:log2(DEPTH)], HWRITE and an error flag.
REQ-007 The error flag SHALL be set when either of these holds: (a) the word index is >= DEPTH, or any HADDR bit above the index field is nonzero; (b) HSIZE > log2(AHBW/8).
REQ-008 The state machine SHALL have exactly the states IDLE, WAIT, ERR1 and ERR2.
REQ-009 An accepted OKAY transfer SHALL leave the state as follows:
- WAIT_STATES>0: go to WAIT and load a counter with WAIT_STATES-1.
- WAIT_STATES=0: stay in IDLE and complete the transfer on the next cycle with zero waits.
REQ-010 In WAIT, HREADYOUT SHALL be 0. The counter SHALL decrement each cycle. When the counter reaches 0, the next cycle SHALL return to IDLE with HREADYOUT=1 as the completing cycle.
REQ-011 An accepted transfer with the error flag set SHALL go to ERR1, then ERR2, then IDLE:
- ERR1: HRESP=1, HREADYOUT=0.
- ERR2: HRESP=1, HREADYOUT=1.
- No storage access occurs.
REQ-012 In IDLE, HREADYOUT SHALL be 1 and HRESP SHALL be 0. IDLE and BUSY transfers, and transfers with HSEL=0, SHALL receive this zero-wait OKAY response.
REQ-013 On the completing cycle of a write, storage byte lanes with HWSTRB[i]=1 SHALL be updated from HWDATA at the clk edge that ends that cycle; lanes with HWSTRB[i]=0 SHALL be unchanged.
REQ-014 HRDATA SHALL equal storage[registered index] during a read data phase, including its wait cycles, and SHALL be 0 at all other times.
REQ-015 A new address phase presented on a completing cycle (HREADY=1) SHALL be accepted in that same cycle, giving back-to-back pipelining.
REQ-016 A read that immediately follows a write to the same word SHALL return the newly written data.
REQ-017 A new address phase presented on ERR1 SHALL be ignored, because HREADY=0 on that cycle. One presented on ERR2 SHALL be accepted.
REQ-018 While in WAIT or ERR1, the block SHALL ignore HADDR, HTRANS, HWRITE and HSIZE.

Reset
REQ-019 Asserting reset SHALL immediately, without waiting for a clk edge, force state=IDLE, counter=0, HREADYOUT=1, HRESP=0 and HRDATA=0, and SHALL clear the registered index, write flag and error flag.
REQ-020 Storage contents SHALL NOT be reset. A transfer interrupted by reset SHALL be abandoned; an interrupted write SHALL leave storage unchanged.
REQ-021 After reset is released, the first clk edge SHALL be able to accept a new address phase.

Verification
REQ-022 WAIT_STATES=2, AHBW=64. Write 0x1122334455667788 to address 0x10 with HWSTRB=0xFF, then read 0x10. Required: each data phase shows HREADYOUT low for 2 cycles, and the read returns 0x1122334455667788 with HRESP=0.
REQ-023 Partial write. Word 0x10 holds 0x1122334455667788; write 0xAAAAAAAAAAAAAAAA with HWSTRB=0x0F, then read 0x10. Required: read returns 0x11223344AAAAAAAA.
REQ-024 DEPTH=256, AHBW=64. Read address 0x800 (index 256). Required: ERR1 (HRESP=1, HREADYOUT=0), then ERR2 (HRESP=1, HREADYOUT=1), then IDLE; storage unchanged. Repeat with HSIZE=3'b100: same error response.
REQ-025 WAIT_STATES=0. Issue back-to-back NONSEQ write to 0x0 with data 5, then read of 0x0. Required: each transfer completes in 1 cycle, and the read returns 5.
REQ-026 WAIT_STATES=2. Assert reset during the WAIT state of a write of 0xFF to 0x8, where 0x8 previously held 0. Required: HREADYOUT=1 and HRESP=0 before the next clk edge, and a subsequent read of 0x8 returns 0.
REQ-027 Issue HTRANS=IDLE with HSEL=1, and separately a NONSEQ transfer with HSEL=0. Required: HREADYOUT stays 1, HRESP stays 0, and storage is untouched.
